// File: rtl/data_sram_responder.sv
// SRAM-like data-memory slave: accepts req/addr_ok requests into an in-order
// response queue and answers on data_ok/rdata after a fixed latency.
module data_sram_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  input  logic        stall_addr,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [3:0]    CNT_INIT = 4'(LATENCY - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [31:0]       mem_q [0:(1<<ADDR_W)-1];

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  wr_q, wr_d;
  logic [31:0]       rdata_q [DEPTH];
  logic [31:0]       rdata_d [DEPTH];
  logic [3:0]        cnt_q [DEPTH];
  logic [3:0]        cnt_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [ADDR_W-1:0] idx;
  logic              acc;
  logic              pop;

  // Size and the address bits outside the word index do not affect behaviour.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    idx               = data_sram_addr[ADDR_W+1:2];
    data_sram_addr_ok = resetn & ~stall_addr & (count_q < CNT_FULL);
    acc               = data_sram_req & data_sram_addr_ok;
    data_sram_data_ok = valid_q[head_q] & (cnt_q[head_q] == 4'd0);
    pop               = data_sram_data_ok;
    data_sram_rdata   = (data_sram_data_ok & ~wr_q[head_q]) ? rdata_q[head_q] : '0;
  end

  always_comb begin
    valid_d = valid_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (cnt_q[i] != 4'd0)) cnt_d[i] = cnt_q[i] - 4'd1;
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end

    // Pop is applied first; push cannot land on the head slot because a full
    // queue blocks acceptance.
    if (acc) begin
      valid_d[tail_q] = 1'b1;
      wr_d[tail_q]    = data_sram_wr;
      rdata_d[tail_q] = mem_q[idx];
      cnt_d[tail_q]   = CNT_INIT;
      tail_d          = ptr_inc(tail_q);
    end

    case ({acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload fields are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    rdata_q <= rdata_d;
    cnt_q   <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (acc && data_sram_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: a LATENCY=2/DEPTH=3 instance checked
// through a response queue, plus a LATENCY=4/DEPTH=2 instance for back-pressure.
module tb_data_sram_responder;

  localparam int unsigned LAT_A = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;

  logic        a_req, a_wr;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_addr_ok, a_data_ok;
  logic [31:0] a_rdata;

  logic        b_req;
  logic [31:0] b_addr;
  logic        b_addr_ok, b_data_ok;
  logic [31:0] b_rdata_unused;
  logic        b_stall = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_responder #(.ADDR_W(10), .LATENCY(LAT_A), .DEPTH(3)) dut_a (
    .clk(clk), .resetn(resetn),
    .data_sram_req(a_req), .data_sram_wr(a_wr), .data_sram_size(2'd2),
    .data_sram_addr(a_addr), .data_sram_wstrb(a_wstrb), .data_sram_wdata(a_wdata),
    .stall_addr(stall),
    .data_sram_addr_ok(a_addr_ok), .data_sram_data_ok(a_data_ok), .data_sram_rdata(a_rdata)
  );

  data_sram_responder #(.ADDR_W(10), .LATENCY(4), .DEPTH(2)) dut_b (
    .clk(clk), .resetn(resetn),
    .data_sram_req(b_req), .data_sram_wr(1'b0), .data_sram_size(2'd2),
    .data_sram_addr(b_addr), .data_sram_wstrb(4'h0), .data_sram_wdata(32'h0),
    .stall_addr(b_stall),
    .data_sram_addr_ok(b_addr_ok), .data_sram_data_ok(b_data_ok), .data_sram_rdata(b_rdata_unused)
  );

  // Monitor: every data_ok pops one expected response and checks data and cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (a_data_ok) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_data_ok cyc=%0d rdata=%h, required no response", cyc, a_rdata);
        end else begin
          e = sb.pop_front();
          if (a_rdata !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL response got rdata=%h cyc=%0d, required rdata=%h cyc=%0d",
                     a_rdata, cyc, e.data, e.cyc);
          end
        end
      end else begin
        if (a_rdata !== 32'h0) begin
          errors++;
          $display("FAIL idle_rdata cyc=%0d got %h, required 0", cyc, a_rdata);
        end
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_response cyc=%0d, required rdata=%h at cyc=%0d",
                   cyc, sb[0].data, sb[0].cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h, required %h", name, cyc, got, want);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input bit track);
    int ec;
    a_req = 1'b1; a_wr = wr; a_addr = addr; a_wstrb = strb; a_wdata = wd;
    @(negedge clk);
    check("accept", {31'b0, a_addr_ok}, 32'd1);
    if (track) begin
      ec = (cyc + LAT_A > last + 1) ? cyc + LAT_A : last + 1;
      last = ec;
      sb.push_back('{data: wr ? 32'h0 : exp_rd, cyc: ec});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp_ao;
    logic [7:0] exp_do;

    resetn = 1'b0; stall = 1'b0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wstrb = '0; a_wdata = '0;
    b_req = 1'b0; b_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_addr_ok_a", {31'b0, a_addr_ok}, 32'd0);
    check("reset_addr_ok_b", {31'b0, b_addr_ok}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_reset_data_ok", {31'b0, a_data_ok}, 32'd0);
    check("post_reset_addr_ok", {31'b0, a_addr_ok}, 32'd1);
    @(posedge clk); #1;

    // Single read after a full-word preload.
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b1);
    idle(); idle();
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
    repeat (3) idle();

    // Strobed write merges into the existing word.
    issue(1'b1, 32'h20, 4'hF, 32'hAAAAAAAA, 32'h0, 1'b1);
    issue(1'b1, 32'h20, 4'b0110, 32'h11223344, 32'h0, 1'b1);
    issue(1'b0, 32'h20, 4'h0, 32'h0, 32'hAA2233AA, 1'b1);

    // Upper address bits alias onto the same word.
    issue(1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 32'h0, 1'b1);
    issue(1'b0, 32'h1030, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1);
    repeat (3) idle();

    // Streaming: 8 writes then 8 back-to-back reads.
    for (int k = 0; k < 8; k++)
      issue(1'b1, 32'h100 + 32'(4*k), 4'hF, 32'h10000000 + 32'(k) * 32'h01010101, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++)
      issue(1'b0, 32'h100 + 32'(4*k), 4'h0, 32'h0, 32'h10000000 + 32'(k) * 32'h01010101, 1'b1);
    repeat (4) idle();

    // stall_addr blocks acceptance while the earlier request still responds.
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
    stall = 1'b1; a_req = 1'b1; a_wr = 1'b0; a_addr = 32'h20;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_addr_ok", {31'b0, a_addr_ok}, 32'd0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    issue(1'b0, 32'h20, 4'h0, 32'h0, 32'hAA2233AA, 1'b1);
    repeat (4) idle();

    // Back-pressure on the LATENCY=4, DEPTH=2 instance; bit k = cycle k.
    exp_ao = 8'b0110_0011;
    exp_do = 8'b0011_0000;
    b_req = 1'b1; b_addr = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("bp_addr_ok_c%0d", k), {31'b0, b_addr_ok}, {31'b0, exp_ao[k]});
      check($sformatf("bp_data_ok_c%0d", k), {31'b0, b_data_ok}, {31'b0, exp_do[k]});
      @(posedge clk); #1;
    end
    b_req = 1'b0;
    repeat (6) idle();

    // Reset with reads outstanding: the untracked read must never respond.
    issue(1'b1, 32'h40, 4'hF, 32'h5A5A1234, 32'h0, 1'b1);
    issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
    issue(1'b0, 32'h14, 4'h0, 32'h0, 32'h0, 1'b0);
    a_req = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("mid_reset_addr_ok", {31'b0, a_addr_ok}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("after_reset_addr_ok", {31'b0, a_addr_ok}, 32'd1);
    check("after_reset_data_ok", {31'b0, a_data_ok}, 32'd0);
    @(posedge clk); #1;
    repeat (3) idle();
    issue(1'b0, 32'h40, 4'h0, 32'h0, 32'h5A5A1234, 1'b1);

    repeat (12) idle();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Slave end of the SRAM-like data-memory interface driven by the CPU's EXE/MEM stages. It accepts requests on a `req`/`addr_ok` handshake, commits writes and samples read data at acceptance, and returns in-order responses on `data_ok`/`rdata` after a programmable latency. It is backed by an internal word-addressed RAM, and it stands in for the data RAM in simulation so that stages waiting on `data_sram_data_ok` can be exercised with multi-cycle and back-pressured memory.

## Interface
- `ADDR_W`, 10: log2 of RAM depth in 32-bit words; word index = `addr[ADDR_W+1:2]`, upper address bits ignored (aliasing).
- `LATENCY`, 2: cycles from acceptance to earliest `data_ok`; legal range 1..15.
- `DEPTH`, 2: outstanding-request queue depth; legal range 1..8. `DEPTH >= LATENCY+1` gives 1 request/cycle throughput.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `data_sram_req` in 1: request valid.
- `data_sram_wr` in 1: 1 = write, 0 = read.
- `data_sram_size` in 2: 0 = byte, 1 = half, 2 = word; informational only, since byte lanes come from `wstrb`.
- `data_sram_addr` in 32: byte address.
- `data_sram_wstrb` in 4: byte enables for writes; ignored on reads.
- `data_sram_wdata` in 32: write data, lane-aligned.
- `stall_addr` in 1: test hook; forces `addr_ok` low.
- `data_sram_addr_ok` out 1: request accepted this cycle when high together with `req`.
- `data_sram_data_ok` out 1: one response completes this cycle.
- `data_sram_rdata` out 32: read word for read responses; 0 for write responses and when `data_ok` is low.

## Operation
- Acceptance: `acc = req & addr_ok`, where `addr_ok = resetn & ~stall_addr & (count < DEPTH)`. `addr_ok` does not depend on `req`.
- On acceptance:
  - Write: for each lane i with `wstrb[i]=1`, `mem[idx][8i+7:8i] <= wdata[8i+7:8i]`.
  - Read: `mem[idx]` is captured into the new queue entry in the same edge; the capture sees pre-write contents of any same-edge write (impossible anyway, since there is one request per cycle).
- Queue entry fields: `{wr, rdata[31:0], cnt[3:0]}`. `cnt` is initialised to `LATENCY-1`. Every valid entry with `cnt != 0` decrements each cycle, all in parallel.
- Response: `data_ok = head_valid & (head.cnt == 0)`. `rdata = head.wr ? 0 : head.rdata` while `data_ok` is high. The head pops at the end of that cycle. There is no back-pressure on `data_ok`; the master always consumes it.
- Ordering: responses are strictly in acceptance order. A read accepted after a write to the same word returns the written data. Memory is never updated at response time.
- Queue structure: circular buffer with `head`/`tail` pointers (`$clog2(DEPTH)` bits, wrapping at DEPTH) and `count` (0..DEPTH).
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: `count == DEPTH` drops `addr_ok` even if the head pops this cycle; there is no same-cycle pass-through of free space.
- `size` and misalignment are not checked; the EXE stage raises ALE before issuing a request.
- Reset (`resetn=0` at an edge): `count`, `head`, `tail` and all entry valids clear. Outstanding responses are discarded and never signalled. Writes already committed remain in RAM. RAM contents are not reset.

## Timing
- Reset values: `addr_ok=0` while `resetn=0`. `data_ok=0` and `rdata=0` in the first cycle after reset.
- Request accepted at the edge ending cycle C → `data_ok` high in cycle C+LATENCY if the queue ahead of it is empty; otherwise the cycle after the preceding response, whichever is later.
- `LATENCY=1`: response in the cycle immediately after acceptance.
- Throughput: with `DEPTH >= LATENCY+1`, one request accepted and one response returned per cycle in steady state.
- `addr_ok` reflects registered `count` and `stall_addr` only. Its path to the output is combinational from registers plus `stall_addr`, with no path from `req`.
- `data_ok` and `rdata` are combinational from registered queue state only, with no input-to-output paths.
- `stall_addr` asserted mid-burst: acceptance stops that cycle; queued entries keep counting down and responding.

## Test plan
- Single read, `LATENCY=2`: preload `mem[4]=32'hDEADBEEF`; read addr `0x10` accepted in cycle 0 → `data_ok=1`, `rdata=32'hDEADBEEF` in cycle 2 only.
- Strobed write then read: write `0x20`, `wdata=32'h11223344`, `wstrb=4'b0110` over `32'hAAAAAAAA`; next-cycle read of `0x20` → `rdata=32'hAA2233AA`. The write's own `data_ok` carries `rdata=0`.
- Streaming, `LATENCY=2`, `DEPTH=3`: 8 consecutive reads with `req` held high → `addr_ok` high all 8 cycles, then 8 consecutive `data_ok` pulses in cycles 2..9 with data in order.
- Back-pressure, `LATENCY=4`, `DEPTH=2`: `req` held high → accepts in cycles 0 and 1, `addr_ok=0` in cycles 2–4, `data_ok` in cycles 4 and 5, third accept in cycle 5.
- `stall_addr` high in cycles 1–3 with `req` held high → no acceptance in cycles 1–3. The response for the cycle-0 request still arrives in cycle LATENCY.
- Reset mid-operation: two reads outstanding, `resetn=0` for one cycle → no `data_ok` afterward, `addr_ok=0` during reset and high the cycle after. A write committed before reset is readable after it.
